id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be updated on the rising edge of clk.
REQ-002 The block SHALL use the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the offered instruction this cycle.
- id_alu_control  in  4  ALU opcode.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_alu_src_imm  in  1  srcb selects the immediate.
- id_reg_write  in  1  instruction writes rd.
- flush  in  1  kill the held instruction and any instruction accepted this cycle.
- mem_fwd_valid, mem_is_load  in  1 each  the EX/MEM producer writes mem_rd; mem_is_load marks it as a load.
- mem_rd  in  5  EX/MEM destination index.
- mem_result  in  32  EX/MEM forwarding value.
- wb_fwd_valid  in  1  the MEM/WB producer writes wb_rd.
- wb_rd  in  5  MEM/WB destination index.
- wb_result  in  32  MEM/WB forwarding value.
- ex_ready  in  1  the ALU/EX-MEM side consumes this cycle.
- ex_valid  out  1  srca, srcb and alu_control are usable.
- alu_control  out  4  ALU opcode to the ALU.
- srca, srcb  out  32 each  ALU operands.
- store_data  out  32  forwarded rs2 value.
- ex_rd  out  5  destination index.
- ex_reg_write  out  1  write-enable.
- load_use_stall  out  1  hazard indicator.
- stall_count  out  32  performance counter.

Function
REQ-003 The block SHALL hold one instruction in an internal held bit (hv); the held register set SHALL be alu_control, rs1, rs2, rd, rs1 value, rs2 value, imm, alu_src_imm and reg_write.
REQ-004 A hazard SHALL exist when all of the following hold: hv, mem_fwd_valid, mem_is_load, mem_rd!=0, and mem_rd equals the held rs1, or mem_rd equals the held rs2 with alu_src_imm=0.
- load_use_stall SHALL equal this hazard combinationally.
REQ-005 ex_valid SHALL equal hv AND NOT hazard.
REQ-006 id_ready SHALL equal NOT hv OR (ex_ready AND NOT hazard), combinationally.
REQ-007 An accept SHALL occur when id_valid AND id_ready; on an accept, all held registers SHALL load from the id_* inputs and hv SHALL become 1 at the next edge.
REQ-008 When id_ready=1 and id_valid=0, hv SHALL become 0 at the next edge (bubble).
REQ-009 When hv=1 and id_ready=0, the instruction SHALL be held and its held registers SHALL keep their values, except as stated in REQ-010.
REQ-010 While an instruction is held (not replaced) and wb_fwd_valid=1 with wb_rd!=0, wb_result SHALL be written into the held rs1 value if wb_rd equals rs1, and into the held rs2 value if wb_rd equals rs2.
REQ-011 Operand forwarding SHALL be combinational on the held values, per operand:
- first choice: mem_result, when mem_fwd_valid, NOT mem_is_load, mem_rd!=0 and mem_rd equals the index;
- else wb_result, when wb_fwd_valid, wb_rd!=0 and wb_rd equals the index;
- else the held value.
REQ-012 Index 0 SHALL never be forwarded.
REQ-013 srca SHALL be the forwarded rs1 value.
REQ-014 srcb SHALL be imm when alu_src_imm=1, else the forwarded rs2 value.
REQ-015 store_data SHALL always be the forwarded rs2 value.
REQ-016 alu_control, ex_rd and ex_reg_write SHALL come directly from the held registers.
REQ-017 flush=1 SHALL force hv to 0 at the next edge, with priority over accept, bubble and hold; id_ready SHALL still follow REQ-006, and any instruction it accepts SHALL be discarded.
REQ-018 stall_count SHALL increment by 1 on each edge where load_use_stall=1, SHALL saturate at 32'hFFFFFFFF, and SHALL NOT wrap.
REQ-019 Latency SHALL be one cycle from accept to ex_valid when no hazard exists.
REQ-020 Throughput SHALL be one instruction per cycle while ex_ready=1 and no hazard exists.
REQ-021 An alu_control value outside the ALU's defined set SHALL be passed through unchanged; this stage SHALL NOT check it.

Reset
REQ-022 While rst_n=0, hv, every held register and stall_count SHALL be 0, independent of clk.
REQ-023 During reset the outputs SHALL therefore be: ex_valid=0, alu_control=4'b0000, srca=srcb=store_data=0, ex_rd=0, ex_reg_write=0, and id_ready=1.
REQ-024 A reset asserted mid-operation SHALL discard the held instruction without producing a consume.

Verification
REQ-025 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Basic pass-through: accept rs1_data=5, imm=7, alu_src_imm=1, alu_control=0 -> next cycle ex_valid=1, srca=5, srcb=7.
- Forwarding priority: held rs1=3; mem_rd=3, mem_result=0xAA (non-load) and wb_rd=3, wb_result=0xBB -> srca=0xAA; drop mem_fwd_valid -> srca=0xBB.
- Load-use: held rs2=4, alu_src_imm=0; mem_is_load=1, mem_rd=4 for 2 cycles -> ex_valid=0, id_ready=0, stall_count=2; then rs2 captured from wb_result=0x55 -> srcb=0x55.
- Backpressure: ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, held values stable; ex_ready=1 -> next instruction accepted.
- x0 and flush: wb_rd=0 with held rs1=0 -> srca unchanged; flush together with an accept -> ex_valid=0 next cycle.
- Async reset: assert rst_n=0 mid-clock while hv=1 -> ex_valid=0 and stall_count=0 immediately.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: holds one decoded instruction, forwards operands from
// EX/MEM and MEM/WB, detects load-use hazards and counts stall cycles.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [3:0]  id_alu_control,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic        id_alu_src_imm,
  input  logic        id_reg_write,
  input  logic        flush,
  input  logic        mem_fwd_valid,
  input  logic        mem_is_load,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_fwd_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [3:0]  alu_control,
  output logic [31:0] srca,
  output logic [31:0] srcb,
  output logic [31:0] store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        load_use_stall,
  output logic [31:0] stall_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned AW   = 4;

  logic            hv_q, hv_d;
  logic [AW-1:0]   alu_q, alu_d;
  logic [RW-1:0]   rs1_q, rs1_d;
  logic [RW-1:0]   rs2_q, rs2_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] v1_q, v1_d;
  logic [XLEN-1:0] v2_q, v2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            src_imm_q, src_imm_d;
  logic            rw_q, rw_d;
  logic [XLEN-1:0] stall_q, stall_d;

  logic            hazard_c;
  logic            ready_c;
  logic            accept_c;
  logic            wb_live_c;
  logic [XLEN-1:0] fwd1_c;
  logic [XLEN-1:0] fwd2_c;

  // Load-use hazard and handshake
  always_comb begin
    hazard_c = hv_q & mem_fwd_valid & mem_is_load & (mem_rd != '0) &
               ((mem_rd == rs1_q) | ((mem_rd == rs2_q) & ~src_imm_q));
    ready_c  = ~hv_q | (ex_ready & ~hazard_c);
    accept_c = id_valid & ready_c;
    wb_live_c = wb_fwd_valid & (wb_rd != '0);
  end

  // Operand forwarding: EX/MEM non-load result beats MEM/WB; x0 never forwarded
  always_comb begin
    fwd1_c = v1_q;
    fwd2_c = v2_q;
    if (mem_fwd_valid && !mem_is_load && (mem_rd != '0) && (mem_rd == rs1_q)) begin
      fwd1_c = mem_result;
    end else if (wb_live_c && (wb_rd == rs1_q)) begin
      fwd1_c = wb_result;
    end
    if (mem_fwd_valid && !mem_is_load && (mem_rd != '0) && (mem_rd == rs2_q)) begin
      fwd2_c = mem_result;
    end else if (wb_live_c && (wb_rd == rs2_q)) begin
      fwd2_c = wb_result;
    end
  end

  // Next state: accept loads, a held instruction captures write-backs
  always_comb begin
    hv_d      = hv_q;
    alu_d     = alu_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    imm_d     = imm_q;
    src_imm_d = src_imm_q;
    rw_d      = rw_q;
    stall_d   = stall_q;

    if (accept_c) begin
      alu_d     = id_alu_control;
      rs1_d     = id_rs1;
      rs2_d     = id_rs2;
      rd_d      = id_rd;
      v1_d      = id_rs1_data;
      v2_d      = id_rs2_data;
      imm_d     = id_imm;
      src_imm_d = id_alu_src_imm;
      rw_d      = id_reg_write;
    end else if (hv_q && wb_live_c) begin
      if (wb_rd == rs1_q) v1_d = wb_result;
      if (wb_rd == rs2_q) v2_d = wb_result;
    end

    if (flush) begin
      hv_d = 1'b0;
    end else if (accept_c) begin
      hv_d = 1'b1;
    end else if (ready_c) begin
      hv_d = 1'b0;
    end

    if (hazard_c && (stall_q != '1)) begin
      stall_d = stall_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q      <= 1'b0;
      alu_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      imm_q     <= '0;
      src_imm_q <= 1'b0;
      rw_q      <= 1'b0;
      stall_q   <= '0;
    end else begin
      hv_q      <= hv_d;
      alu_q     <= alu_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      imm_q     <= imm_d;
      src_imm_q <= src_imm_d;
      rw_q      <= rw_d;
      stall_q   <= stall_d;
    end
  end

  assign id_ready       = ready_c;
  assign load_use_stall = hazard_c;
  assign ex_valid       = hv_q & ~hazard_c;
  assign alu_control    = alu_q;
  assign srca           = fwd1_c;
  assign srcb           = src_imm_q ? imm_q : fwd2_c;
  assign store_data     = fwd2_c;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = rw_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the held instruction.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [3:0]  id_alu_control;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src_imm, id_reg_write;
  logic        flush;
  logic        mem_fwd_valid, mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_fwd_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  alu_control;
  logic [31:0] srca, srcb, store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        load_use_stall;
  logic [31:0] stall_count;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_control(id_alu_control),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src_imm(id_alu_src_imm), .id_reg_write(id_reg_write),
    .flush(flush),
    .mem_fwd_valid(mem_fwd_valid), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_fwd_valid(wb_fwd_valid), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_ready(ex_ready),
    .ex_valid(ex_valid), .alu_control(alu_control),
    .srca(srca), .srcb(srcb), .store_data(store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: the instruction currently sitting in the stage
  bit          m_hv;
  logic [3:0]  m_alu;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_v1, m_v2, m_imm;
  bit          m_src_imm, m_rw;
  logic [31:0] m_stall;

  task automatic model_reset();
    m_hv = 0; m_alu = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_v1 = '0; m_v2 = '0; m_imm = '0; m_src_imm = 0; m_rw = 0; m_stall = '0;
  endtask

  function automatic bit m_hazard();
    if (!m_hv || !mem_fwd_valid || !mem_is_load || mem_rd == 5'd0) return 0;
    return (mem_rd == m_rs1) || (mem_rd == m_rs2 && !m_src_imm);
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] held);
    if (idx == 5'd0) return held;
    if (mem_fwd_valid && !mem_is_load && mem_rd == idx) return mem_result;
    if (wb_fwd_valid && wb_rd == idx) return wb_result;
    return held;
  endfunction

  function automatic bit m_ready();
    return !m_hv || (ex_ready && !m_hazard());
  endfunction

  task automatic check_model();
    logic [31:0] o2;
    o2 = operand(m_rs2, m_v2);
    check("ex_valid",       32'(ex_valid),       32'(m_hv && !m_hazard()));
    check("id_ready",       32'(id_ready),       32'(m_ready()));
    check("load_use_stall", 32'(load_use_stall), 32'(m_hazard()));
    check("alu_control",    32'(alu_control),    32'(m_alu));
    check("srca",           srca,                operand(m_rs1, m_v1));
    check("srcb",           srcb,                m_src_imm ? m_imm : o2);
    check("store_data",     store_data,          o2);
    check("ex_rd",          32'(ex_rd),          32'(m_rd));
    check("ex_reg_write",   32'(ex_reg_write),   32'(m_rw));
    check("stall_count",    stall_count,         m_stall);
  endtask

  // Check current outputs, advance model and DUT one clock, return at negedge
  task automatic step();
    bit acc, rdy, haz;
    #1;
    check_model();
    haz = m_hazard();
    rdy = m_ready();
    acc = id_valid && rdy;
    @(posedge clk);
    if (haz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (acc) begin
      m_alu = id_alu_control; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_v1 = id_rs1_data; m_v2 = id_rs2_data; m_imm = id_imm;
      m_src_imm = id_alu_src_imm; m_rw = id_reg_write;
    end else if (m_hv && wb_fwd_valid && wb_rd != 5'd0) begin
      if (wb_rd == m_rs1) m_v1 = wb_result;
      if (wb_rd == m_rs2) m_v2 = wb_result;
    end
    if (flush) m_hv = 0;
    else if (acc) m_hv = 1;
    else if (rdy) m_hv = 0;
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_alu_control = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_src_imm = 0;
    id_reg_write = 0; flush = 0; mem_fwd_valid = 0; mem_is_load = 0;
    mem_rd = '0; mem_result = '0; wb_fwd_valid = 0; wb_rd = '0;
    wb_result = '0; ex_ready = 1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [31:0] imm, input bit sel_imm, input logic [4:0] rd);
    id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_imm = imm; id_alu_src_imm = sel_imm; id_rd = rd; id_reg_write = 1;
    id_alu_control = 4'd0;
  endtask

  logic [31:0] base;

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #3;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    check("rst_srca", srca, 32'd0);
    @(negedge clk);
    step();
    rst_n = 1;
    step();

    // Basic pass-through
    offer(5'd1, 32'd5, 5'd2, 32'd0, 32'd7, 1, 5'd9);
    step();
    idle();
    #1;
    check("pass_ex_valid", 32'(ex_valid), 32'd1);
    check("pass_srca", srca, 32'd5);
    check("pass_srcb", srcb, 32'd7);
    step();

    // Forwarding priority
    offer(5'd3, 32'h11, 5'd0, 32'd0, 32'd0, 1, 5'd8);
    step();
    idle();
    ex_ready = 0;
    mem_fwd_valid = 1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_fwd_valid = 1; wb_rd = 5'd3; wb_result = 32'hBB;
    #1;
    check("fwd_mem_first", srca, 32'hAA);
    step();
    mem_fwd_valid = 0;
    #1;
    check("fwd_wb_second", srca, 32'hBB);
    step();

    // Load-use stall with write-back capture
    idle();
    offer(5'd1, 32'h10, 5'd4, 32'h44, 32'h0, 0, 5'd6);
    step();
    base = m_stall;
    idle();
    mem_fwd_valid = 1; mem_is_load = 1; mem_rd = 5'd4;
    #1;
    check("lu_ex_valid", 32'(ex_valid), 32'd0);
    check("lu_id_ready", 32'(id_ready), 32'd0);
    step();
    wb_fwd_valid = 1; wb_rd = 5'd4; wb_result = 32'h55;
    step();
    idle();
    #1;
    check("lu_stall_count", stall_count, base + 32'd2);
    check("lu_srcb", srcb, 32'h55);
    check("lu_resume", 32'(ex_valid), 32'd1);
    step();

    // Backpressure
    offer(5'd5, 32'h1234, 5'd6, 32'h5678, 32'h0, 0, 5'd7);
    step();
    offer(5'd2, 32'h9, 5'd3, 32'h8, 32'h0, 0, 5'd12);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_id_ready", 32'(id_ready), 32'd0);
      check("bp_srca_stable", srca, 32'h1234);
      step();
    end
    ex_ready = 1;
    step();
    idle();
    #1;
    check("bp_next_rd", 32'(ex_rd), 32'd12);
    step();

    // x0 never forwarded or written back
    offer(5'd0, 32'h123, 5'd0, 32'h0, 32'h0, 0, 5'd1);
    step();
    idle();
    ex_ready = 0;
    wb_fwd_valid = 1; wb_rd = 5'd0; wb_result = 32'hDEAD;
    mem_fwd_valid = 1; mem_rd = 5'd0; mem_result = 32'hBEEF;
    #1;
    check("x0_srca", srca, 32'h123);
    step();
    #1;
    check("x0_srca_held", srca, 32'h123);
    // Flush together with an accept
    idle();
    offer(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 0, 5'd3);
    flush = 1;
    #1;
    check("flush_id_ready", 32'(id_ready), 32'd1);
    step();
    idle();
    #1;
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    step();

    // Async reset mid-cycle with a held instruction
    offer(5'd4, 32'h77, 5'd0, 32'h0, 32'h0, 1, 5'd4);
    step();
    idle();
    ex_ready = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("arst_ex_valid", 32'(ex_valid), 32'd0);
    check("arst_stall", stall_count, 32'd0);
    check("arst_id_ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      id_valid       = ($urandom_range(0, 3) != 0);
      id_alu_control = 4'($urandom);
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      id_rd          = 5'($urandom_range(0, 7));
      id_rs1_data    = $urandom;
      id_rs2_data    = $urandom;
      id_imm         = $urandom;
      id_alu_src_imm = $urandom_range(0, 1) == 1;
      id_reg_write   = $urandom_range(0, 1) == 1;
      flush          = ($urandom_range(0, 19) == 0);
      mem_fwd_valid  = $urandom_range(0, 1) == 1;
      mem_is_load    = ($urandom_range(0, 2) == 0);
      mem_rd         = ($urandom_range(0, 1) == 1) ? m_rs2 : 5'($urandom_range(0, 7));
      mem_result     = $urandom;
      wb_fwd_valid   = $urandom_range(0, 1) == 1;
      wb_rd          = ($urandom_range(0, 1) == 1) ? m_rs1 : 5'($urandom_range(0, 7));
      wb_result      = $urandom;
      ex_ready       = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
